// File: rtl/ext_ram_burst_pkg.sv
// Shared state encoding, default parameters and sizing helper for the
// external frame/side-info memory model.
package ext_ram_burst_pkg;

    localparam int DEF_DATA_BYTES = 4;
    localparam int DEF_ADDR_W     = 26;
    localparam int DEF_DEPTH      = 8000001;
    localparam int DEF_RD_LAT     = 1;
    localparam int DEF_BURST_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_e;

    // Width of a word index; never zero so single-word memories still elaborate.
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ext_ram_rd_align.sv
// Combinational byte aligner: picks DATA_BYTES bytes starting at byte offset
// off_i from the little-endian pair {hi_i, lo_i}.
module ext_ram_rd_align #(
    parameter int DATA_BYTES = 4,
    parameter int OW         = 2
) (
    input  logic [8*DATA_BYTES-1:0] lo_i,
    input  logic [8*DATA_BYTES-1:0] hi_i,
    input  logic [OW-1:0]           off_i,
    output logic [8*DATA_BYTES-1:0] word_o
);
    localparam int DW = 8 * DATA_BYTES;

    logic [2*DW-1:0] cat;

    assign cat    = {hi_i, lo_i};
    assign word_o = DW'(cat >> {off_i, 3'b000});

endmodule

// File: rtl/ext_ram_burst.sv
// Burst read/write memory model with byte-unaligned reads, byte enables and a
// RD_LAT-deep read pipeline. Define EXT_RAM_DUMP_EN to enable the frame dump.
module ext_ram_burst
    import ext_ram_burst_pkg::*;
#(
    parameter int DATA_BYTES = DEF_DATA_BYTES,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int RD_LAT     = DEF_RD_LAT,
    parameter int BURST_W    = DEF_BURST_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req,
    input  logic                    wr,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [BURST_W-1:0]      burst_len,
    output logic                    ready,
    input  logic                    wr_valid,
    input  logic [8*DATA_BYTES-1:0] data_in,
    input  logic [DATA_BYTES-1:0]   byte_en,
    output logic                    rd_valid,
    output logic [8*DATA_BYTES-1:0] data_out,
    input  logic                    end_of_frame,
    input  logic [2:0]              pic_num,
    input  logic [31:0]             frame_words
);
    localparam int DW = 8 * DATA_BYTES;
    localparam int IW = idx_w(DEPTH);
    localparam int OW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    ba_q, ba_d;
    logic [BURST_W-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]        mem_q [DEPTH];

    logic [IW-1:0]        w0, w1;
    logic [OW-1:0]        off;
    logic [DW-1:0]        rd_lo, rd_hi, aligned;
    logic                 issue, wbeat, last;

    logic [RD_LAT:0]          vld_pipe_q;
    logic [RD_LAT:0][DW-1:0]  data_pipe_q;

    assign ready = (state_q == ST_IDLE);
    assign issue = (state_q == ST_RD);
    assign wbeat = (state_q == ST_WR) && wr_valid;
    assign last  = (cnt_q == '0);

    // One byte-address register serves both directions; writes simply ignore
    // its low offset bits.
    always_comb begin
        w0    = IW'(32'(ba_q / ADDR_W'(DATA_BYTES)) % 32'(DEPTH));
        w1    = (w0 == IW'(DEPTH - 1)) ? '0 : w0 + IW'(1);
        off   = OW'(ba_q % ADDR_W'(DATA_BYTES));
        rd_lo = mem_q[w0];
        rd_hi = mem_q[w1];
    end

    always_comb begin
        state_d = state_q;
        ba_d    = ba_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    ba_d    = addr;
                    cnt_d   = burst_len;
                    state_d = wr ? ST_WR : ST_RD;
                end
            end
            ST_RD: begin
                ba_d  = ba_q + ADDR_W'(DATA_BYTES);
                cnt_d = cnt_q - BURST_W'(1);
                if (last) state_d = ST_IDLE;
            end
            ST_WR: begin
                if (wr_valid) begin
                    ba_d  = ba_q + ADDR_W'(DATA_BYTES);
                    cnt_d = cnt_q - BURST_W'(1);
                    if (last) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ba_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ba_q    <= ba_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage is deliberately not reset, like the real external RAM.
    always_ff @(posedge clk) begin
        if (wbeat) begin
            for (int i = 0; i < DATA_BYTES; i++) begin
                if (byte_en[i]) mem_q[w0][8*i +: 8] <= data_in[8*i +: 8];
            end
        end
    end

    ext_ram_rd_align #(
        .DATA_BYTES (DATA_BYTES),
        .OW         (OW)
    ) u_align (
        .lo_i   (rd_lo),
        .hi_i   (rd_hi),
        .off_i  (off),
        .word_o (aligned)
    );

    // Stage 0 captures the issued beat; stages 1..RD_LAT are the latency.
    // Data stages only load behind a valid so data_out holds between beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q  <= '0;
            data_pipe_q <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[RD_LAT-1:0], issue};
            if (issue) data_pipe_q[0] <= aligned;
            for (int i = 1; i <= RD_LAT; i++) begin
                if (vld_pipe_q[i-1]) data_pipe_q[i] <= data_pipe_q[i-1];
            end
        end
    end

    assign rd_valid = vld_pipe_q[RD_LAT];
    assign data_out = data_pipe_q[RD_LAT];

`ifdef EXT_RAM_DUMP_EN
    always @(posedge end_of_frame) begin
        for (longint unsigned i = 0; i < 64'(frame_words); i++) begin
            $display("%h",
                     mem_q[IW'((64'(frame_words) * 64'(pic_num) + i) % 64'(DEPTH))]);
        end
    end
`else
    logic unused_dump;
    assign unused_dump = ^{end_of_frame, pic_num, frame_words};
`endif

endmodule

// File: tb/tb_ext_ram_burst.sv
// Directed bench for ext_ram_burst: DEPTH=16, RD_LAT=2, 32-bit words.
module tb_ext_ram_burst;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [25:0] addr = '0;
    logic [3:0]  burst_len = '0;
    logic        ready;
    logic        wr_valid = 1'b0;
    logic [31:0] data_in = '0;
    logic [3:0]  byte_en = '0;
    logic        rd_valid;
    logic [31:0] data_out;
    logic        end_of_frame = 1'b0;
    logic [2:0]  pic_num = '0;
    logic [31:0] frame_words = '0;

    int total = 0;
    int bad   = 0;

    ext_ram_burst #(
        .DATA_BYTES (4),
        .ADDR_W     (26),
        .DEPTH      (16),
        .RD_LAT     (2),
        .BURST_W    (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .wr           (wr),
        .addr         (addr),
        .burst_len    (burst_len),
        .ready        (ready),
        .wr_valid     (wr_valid),
        .data_in      (data_in),
        .byte_en      (byte_en),
        .rd_valid     (rd_valid),
        .data_out     (data_out),
        .end_of_frame (end_of_frame),
        .pic_num      (pic_num),
        .frame_words  (frame_words)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr_req(input logic [25:0] a, input logic [3:0] len);
        req = 1'b1; wr = 1'b1; addr = a; burst_len = len;
        tick();
        req = 1'b0; wr = 1'b0;
    endtask

    task automatic wr_beat(input logic [31:0] d, input logic [3:0] be);
        wr_valid = 1'b1; data_in = d; byte_en = be;
        tick();
        wr_valid = 1'b0;
    endtask

    // Request accepted at edge T; beats expected at T+3.. with RD_LAT=2.
    task automatic rd_expect(input string tag, input logic [25:0] a, input logic [3:0] len,
                             input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] e [4];
        e = '{e0, e1, e2, e3};
        req = 1'b1; wr = 1'b0; addr = a; burst_len = len;
        tick();
        req = 1'b0;
        tick();
        tick();
        chk({tag, "_pre_vld"}, 32'(rd_valid), 32'd0);
        chk({tag, "_t2_rdy"}, 32'(ready), (len <= 4'd1) ? 32'd1 : 32'd0);
        for (int k = 0; k <= int'(len); k++) begin
            tick();
            chk($sformatf("%s_vld%0d", tag, k), 32'(rd_valid), 32'd1);
            chk($sformatf("%s_dat%0d", tag, k), data_out, e[k]);
        end
        tick();
        chk({tag, "_post_vld"}, 32'(rd_valid), 32'd0);
        chk({tag, "_post_hold"}, data_out, e[len]);
        chk({tag, "_post_rdy"}, 32'(ready), 32'd1);
    endtask

    initial begin
        logic seen_vld;

        // reset state
        tick();
        tick();
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_data_out", data_out, 32'd0);
        rst_n = 1'b1;
        tick();

        // preload words 0..3, 11, 15 and 5
        wr_req(26'd0, 4'd3);
        chk("pre_busy", 32'(ready), 32'd0);
        wr_beat(32'h03020100, 4'hF);
        wr_beat(32'h07060504, 4'hF);
        wr_beat(32'h0B0A0908, 4'hF);
        chk("pre_busy3", 32'(ready), 32'd0);
        wr_beat(32'h0F0E0D0C, 4'hF);
        chk("pre_done", 32'(ready), 32'd1);
        wr_req(26'd44, 4'd0); wr_beat(32'hDEADBEEF, 4'hF);
        wr_req(26'd60, 4'd0); wr_beat(32'h3F3E3D3C, 4'hF);
        wr_req(26'd20, 4'd0); wr_beat(32'hAABBCCDD, 4'hF);

        rd_expect("aligned", 26'd0, 4'd3, 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C);
        rd_expect("unal1", 26'd1, 4'd0, 32'h04030201, 32'h0, 32'h0, 32'h0);
        rd_expect("unal3", 26'd3, 4'd0, 32'h06050403, 32'h0, 32'h0, 32'h0);
        rd_expect("unal_burst", 26'd2, 4'd1, 32'h05040302, 32'h09080706, 32'h0, 32'h0);

        // byte enables; low address bits ignored on write
        wr_req(26'd22, 4'd0);
        wr_beat(32'h11223344, 4'b0101);
        rd_expect("byte_en", 26'd20, 4'd0, 32'hAA22CC44, 32'h0, 32'h0, 32'h0);

        // write stall: words 8..10, word 11 must survive
        wr_req(26'd32, 4'd2);
        wr_beat(32'h11111111, 4'hF);
        chk("stall_b1_rdy", 32'(ready), 32'd0);
        tick();
        chk("stall_gap1_rdy", 32'(ready), 32'd0);
        tick();
        chk("stall_gap2_rdy", 32'(ready), 32'd0);
        wr_beat(32'h22222222, 4'hF);
        chk("stall_b2_rdy", 32'(ready), 32'd0);
        wr_beat(32'h33333333, 4'hF);
        chk("stall_b3_rdy", 32'(ready), 32'd1);
        rd_expect("stall_rb", 26'd32, 4'd3, 32'h11111111, 32'h22222222, 32'h33333333, 32'hDEADBEEF);

        // word index wraps modulo DEPTH
        rd_expect("wrap_unal", 26'd62, 4'd0, 32'h01003F3E, 32'h0, 32'h0, 32'h0);
        rd_expect("wrap_burst", 26'd60, 4'd1, 32'h3F3E3D3C, 32'h03020100, 32'h0, 32'h0);

        // back-to-back; the request held during the busy cycle is ignored
        req = 1'b1; wr = 1'b0; addr = 26'd4; burst_len = 4'd0;
        tick();
        addr = 26'd8;
        tick();
        chk("b2b_rdy", 32'(ready), 32'd1);
        tick();
        req = 1'b0;
        tick();
        chk("b2b_v0", 32'(rd_valid), 32'd1);
        chk("b2b_d0", data_out, 32'h07060504);
        tick();
        chk("b2b_gap", 32'(rd_valid), 32'd0);
        chk("b2b_hold", data_out, 32'h07060504);
        tick();
        chk("b2b_v1", 32'(rd_valid), 32'd1);
        chk("b2b_d1", data_out, 32'h0B0A0908);
        tick();
        chk("b2b_end", 32'(rd_valid), 32'd0);

        // reset during beat 2 of a 4-beat read
        req = 1'b1; wr = 1'b0; addr = 26'd0; burst_len = 4'd3;
        tick();
        req = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_vld", 32'(rd_valid), 32'd0);
        chk("mrst_rdy", 32'(ready), 32'd1);
        chk("mrst_dat", data_out, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        seen_vld = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rd_valid) seen_vld = 1'b1;
        end
        chk("mrst_no_vld", 32'(seen_vld), 32'd0);
        chk("mrst_rdy_after", 32'(ready), 32'd1);
        rd_expect("post_rst", 26'd4, 4'd0, 32'h07060504, 32'h0, 32'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
